wm8731_config_sequencer: RTL and testbench

Sequences the WM8731 register-initialisation writes through the existing I2C master and gates the audio stream until the codec is configured. Owns a fixed 9-entry table of 16-bit control words, retries NACKed or timed-out writes, and handles runtime headphone-volume updates once configured. Sits between the top-level audio playback logic and the I2C protocol block. Replaces the free-running configuration counter.

---
 rtl/wm8731_config_sequencer_if.sv | 25 ++
 rtl/wm8731_config_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_wm8731_config_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_config_sequencer_if.sv
// Handshake between the WM8731 configuration sequencer and the I2C protocol block.
// The sequencer drives start/word; the I2C master reports busy/done/ack.
interface wm8731_config_sequencer_if;
   logic        i2c_start;
   logic [15:0] i2c_word;
   logic        i2c_busy;
   logic        i2c_done;
   logic        i2c_ack_ok;

   modport master (
      output i2c_start,
      output i2c_word,
      input  i2c_busy,
      input  i2c_done,
      input  i2c_ack_ok
   );

   modport slave (
      input  i2c_start,
      input  i2c_word,
      output i2c_busy,
      output i2c_done,
      output i2c_ack_ok
   );
endinterface

// File: rtl/wm8731_config_sequencer.sv
// Writes the WM8731 init table over I2C with retry/timeout, then services
// headphone-volume updates and gates the audio stream until configured.
module wm8731_config_sequencer #(
   parameter int GAP_CYCLES     = 50000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int MAX_RETRY      = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              reconfig_i,
   input  logic                              vol_req_i,
   input  logic [6:0]                        vol_val_i,
   wm8731_config_sequencer_if.master         i2c_if,
   output logic [3:0]                        step_idx_o,
   output logic                              config_done_o,
   output logic                              config_error_o,
   output logic                              stream_enable_o
);

   localparam int CNT_LIM = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_LIM + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 2);
   localparam logic [3:0] LAST_IDX = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_READY,
      S_ERROR
   } state_e;

   function automatic logic [15:0] table_word(input logic [3:0] idx);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'h1E00;
         4'd1:    w = 16'h0C00;
         4'd2:    w = 16'h0812;
         4'd3:    w = 16'h0A00;
         4'd4:    w = 16'h0E23;
         4'd5:    w = 16'h102F;
         4'd6:    w = 16'h0460;
         4'd7:    w = 16'h0660;
         4'd8:    w = 16'h1201;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   // Headphone-out register with LRHPBOTH set so both channels follow.
   function automatic logic [15:0] vol_word(input logic [6:0] val);
      return {7'h02, 1'b1, 1'b0, val};
   endfunction

   state_e             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               start_q, start_d;
   logic [15:0]        word_q, word_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               stream_q, stream_d;
   logic               pend_q, pend_d;
   logic [6:0]         pend_val_q, pend_val_d;
   logic               is_vol_q, is_vol_d;
   logic               last_ok_q, last_ok_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         retry_q    <= '0;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         word_q     <= 16'h0000;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         stream_q   <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         is_vol_q   <= 1'b0;
         last_ok_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         retry_q    <= retry_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         word_q     <= word_d;
         done_q     <= done_d;
         error_q    <= error_d;
         stream_q   <= stream_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         is_vol_q   <= is_vol_d;
         last_ok_q  <= last_ok_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      cnt_d      = cnt_q;
      start_d    = 1'b0;
      word_d     = word_q;
      done_d     = done_q;
      error_d    = error_q;
      stream_d   = stream_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      is_vol_d   = is_vol_q;
      last_ok_d  = last_ok_q;

      case (state_q)
         S_IDLE: begin
            idx_d   = '0;
            state_d = S_ISSUE;
         end

         S_ISSUE: begin
            if (!i2c_if.i2c_busy) begin
               start_d = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
               if (!is_vol_q) begin
                  word_d = table_word(idx_q);
               end else if (last_ok_q) begin
                  // Fresh volume write consumes the pending request;
                  // a volume retry re-sends the word already held.
                  word_d = vol_word(pend_val_q);
                  pend_d = 1'b0;
               end
            end
         end

         S_WAIT: begin
            if (i2c_if.i2c_done && i2c_if.i2c_ack_ok) begin
               retry_d   = '0;
               last_ok_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_GAP;
            end else if (i2c_if.i2c_done || (cnt_q >= CNT_W'(TIMEOUT_CYCLES))) begin
               last_ok_d = 1'b0;
               cnt_d     = '0;
               if (retry_q == RTY_W'(MAX_RETRY)) begin
                  error_d  = 1'b1;
                  stream_d = 1'b0;
                  done_d   = 1'b0;
                  state_d  = S_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_GAP;
               end
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            if (cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               if (!last_ok_q) begin
                  state_d = S_ISSUE;
               end else if (is_vol_q || (idx_q == LAST_IDX)) begin
                  is_vol_d = 1'b0;
                  done_d   = 1'b1;
                  stream_d = 1'b1;
                  state_d  = S_READY;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_READY: begin
            if (reconfig_i) begin
               idx_d    = '0;
               retry_d  = '0;
               done_d   = 1'b0;
               stream_d = 1'b0;
               is_vol_d = 1'b0;
               state_d  = S_ISSUE;
            end else if (pend_q) begin
               is_vol_d  = 1'b1;
               last_ok_d = 1'b1;
               state_d   = S_ISSUE;
            end
         end

         S_ERROR: begin
            if (reconfig_i) begin
               error_d  = 1'b0;
               idx_d    = '0;
               retry_d  = '0;
               done_d   = 1'b0;
               is_vol_d = 1'b0;
               state_d  = S_ISSUE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A request arriving on the issuing cycle is newer, so it re-arms pending.
      if (vol_req_i) begin
         pend_d     = 1'b1;
         pend_val_d = vol_val_i;
      end
   end

   assign i2c_if.i2c_start = start_q;
   assign i2c_if.i2c_word  = word_q;
   assign step_idx_o       = idx_q;
   assign config_done_o    = done_q;
   assign config_error_o   = error_q;
   assign stream_enable_o  = stream_q;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Scoreboard bench: stimulus queues expected I2C words, a monitor pops them on
// every i2c_start; an I2C model answers 20 clocks after each start.
module tb_wm8731_config_sequencer;

   localparam int GAP = 4;
   localparam int TMO = 64;
   localparam int MR  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       reconfig;
   logic       vol_req;
   logic [6:0] vol_val;
   logic [3:0] step_idx;
   logic       config_done;
   logic       config_error;
   logic       stream_enable;

   wm8731_config_sequencer_if bus();

   wm8731_config_sequencer #(
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (MR)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .reconfig_i      (reconfig),
      .vol_req_i       (vol_req),
      .vol_val_i       (vol_val),
      .i2c_if          (bus),
      .step_idx_o      (step_idx),
      .config_done_o   (config_done),
      .config_error_o  (config_error),
      .stream_enable_o (stream_enable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_q[$];
   int          start_log[$];
   int          last_done_cyc = 0;
   logic [15:0] nack_word = 16'h0000;
   int          nack_left = 0;
   logic [15:0] hang_word = 16'h0000;
   int          hang_left = 0;

   logic [15:0] table_words [9] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E23,
                                    16'h102F, 16'h0460, 16'h0660, 16'h1201};

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_table(input int upto);
      for (int i = 0; i <= upto; i++) exp_q.push_back(table_words[i]);
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return config_done;
         1:       return config_error;
         2:       return step_idx == 4'd2;
         3:       return step_idx == 4'd4;
         default: return (step_idx == 4'd6) && bus.i2c_busy;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int bound, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cond(sel)) begin
            hit = 1'b1;
            break;
         end
      end
      check({name, "_reached"}, int'(hit), 1);
   endtask

   task automatic pulse_reconfig();
      @(negedge clk);
      reconfig = 1'b1;
      @(negedge clk);
      reconfig = 1'b0;
   endtask

   task automatic pulse_vol(input logic [6:0] v);
      @(negedge clk);
      vol_req = 1'b1;
      vol_val = v;
      @(negedge clk);
      vol_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start"},  int'(bus.i2c_start), 0);
      check({tag, "_word"},   int'(bus.i2c_word), 0);
      check({tag, "_idx"},    int'(step_idx), 0);
      check({tag, "_done"},   int'(config_done), 0);
      check({tag, "_error"},  int'(config_error), 0);
      check({tag, "_stream"}, int'(stream_enable), 0);
   endtask

   // Monitor: one line per observed transfer start.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (bus.i2c_done) last_done_cyc = cyc;
         if (bus.i2c_start) begin
            start_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_start: got word %04h, required no start", bus.i2c_word);
            end else begin
               e = exp_q.pop_front();
               $display("start @%0d word %04h expected %04h", cyc, bus.i2c_word, e);
               check("i2c_word", int'(bus.i2c_word), int'(e));
            end
         end
      end
   end

   // I2C master model: done 20 clocks after start; may NACK or silently drop.
   initial begin
      int mcnt;
      bit mack;
      bit mdrop;
      mcnt = 0;
      mack = 1'b1;
      mdrop = 1'b0;
      bus.i2c_busy   = 1'b0;
      bus.i2c_done   = 1'b0;
      bus.i2c_ack_ok = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.i2c_done   = 1'b0;
         bus.i2c_ack_ok = 1'b0;
         if (!rst_n) begin
            bus.i2c_busy = 1'b0;
            mcnt = 0;
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               bus.i2c_busy = 1'b0;
               if (!mdrop) begin
                  bus.i2c_done   = 1'b1;
                  bus.i2c_ack_ok = mack;
               end
            end
         end else if (bus.i2c_start) begin
            bus.i2c_busy = 1'b1;
            mcnt  = 19;
            mack  = 1'b1;
            mdrop = 1'b0;
            if (bus.i2c_word == nack_word && nack_left > 0) begin
               mack = 1'b0;
               nack_left--;
            end
            if (bus.i2c_word == hang_word && hang_left > 0) begin
               mdrop = 1'b1;
               hang_left--;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rel;
      int ns;
      int n;
      int first_gap;
      bit low_seen;

      rst_n    = 1'b1;
      reconfig = 1'b0;
      vol_req  = 1'b0;
      vol_val  = 7'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // Clean init, all ACK.
      push_table(8);
      ns = start_log.size();
      rel = cyc;
      rst_n = 1'b1;
      wait_sig(0, 2000, "init_done");
      check("done_latency", cyc - last_done_cyc, 5);
      first_gap = (start_log.size() > ns) ? (start_log[ns] - rel) : -1;
      check("first_start_after_release", int'(first_gap >= 2), 1);
      check("init_stream", int'(stream_enable), 1);
      check("init_error", int'(config_error), 0);
      check("init_idx", int'(step_idx), 8);
      check("init_queue_empty", exp_q.size(), 0);

      // NACK once at index 3.
      nack_word = 16'h0A00;
      nack_left = 1;
      push_table(3);
      exp_q.push_back(16'h0A00);
      for (int i = 4; i <= 8; i++) exp_q.push_back(table_words[i]);
      pulse_reconfig();
      check("reconfig_stream_fall", int'(stream_enable), 0);
      check("reconfig_done_fall", int'(config_done), 0);
      wait_sig(0, 2000, "nack_done");
      check("nack_error", int'(config_error), 0);
      check("nack_stream", int'(stream_enable), 1);
      check("nack_consumed", nack_left, 0);
      check("nack_queue_empty", exp_q.size(), 0);

      // Volume update in READY.
      exp_q.push_back(16'h0579);
      pulse_vol(7'h79);
      low_seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (!stream_enable) low_seen = 1'b1;
      end
      check("vol_stream_held", int'(low_seen), 0);
      check("vol_ready", int'(config_done), 1);
      check("vol_queue_empty", exp_q.size(), 0);

      // Volume requests during init: latest value written once after the table.
      push_table(8);
      exp_q.push_back(16'h0530);
      pulse_reconfig();
      wait_sig(2, 500, "idx2");
      pulse_vol(7'h11);
      wait_sig(3, 500, "idx4");
      pulse_vol(7'h30);
      wait_sig(0, 2000, "pendvol_done");
      check("pendvol_deferred", exp_q.size(), 1);
      repeat (60) @(negedge clk);
      check("pendvol_queue_empty", exp_q.size(), 0);
      check("pendvol_ready", int'(config_done), 1);
      check("pendvol_stream", int'(stream_enable), 1);

      // Dropped transfers at index 5 exhaust retries.
      hang_word = 16'h102F;
      hang_left = 3;
      push_table(5);
      exp_q.push_back(16'h102F);
      exp_q.push_back(16'h102F);
      pulse_reconfig();
      wait_sig(1, 3000, "hang_error");
      n = start_log.size();
      check("hang_spacing_1", int'((start_log[n-1] - start_log[n-2]) >= TMO), 1);
      check("hang_spacing_2", int'((start_log[n-2] - start_log[n-3]) >= TMO), 1);
      check("hang_stream", int'(stream_enable), 0);
      check("hang_done", int'(config_done), 0);
      check("hang_idx", int'(step_idx), 5);
      check("hang_queue_empty", exp_q.size(), 0);
      push_table(8);
      pulse_reconfig();
      check("recover_error_clear", int'(config_error), 0);
      wait_sig(0, 2000, "recover_done");
      check("recover_queue_empty", exp_q.size(), 0);
      check("recover_error", int'(config_error), 0);

      // Reset during WAIT at index 6.
      push_table(6);
      pulse_reconfig();
      wait_sig(4, 1000, "idx6_wait");
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      check("midreset_queue_empty", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      push_table(8);
      rst_n = 1'b1;
      wait_sig(0, 2000, "rerun_done");
      check("rerun_queue_empty", exp_q.size(), 0);
      check("rerun_stream", int'(stream_enable), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
